// File: rtl/status_frame_tx_if.sv
// Bundle of the status-word write port, the byte stream, and the FIFO status lines.
// The slave modport is the frame transmitter's view; master is the surrounding logic's view.
interface status_frame_tx_if #(
  parameter int unsigned DEPTH = 4
);
  logic [23:0]             in_data;
  logic                    in_wr;
  logic [7:0]              tx_byte;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    clear_ovf;

  modport slave (
    input  in_data, in_wr, tx_ready, clear_ovf,
    output tx_byte, tx_valid, level, overflow
  );

  modport master (
    output in_data, in_wr, tx_ready, clear_ovf,
    input  tx_byte, tx_valid, level, overflow
  );
endinterface

// File: rtl/status_frame_tx.sv
// Buffers 24-bit status words in an overwrite-on-full FIFO and emits each one as a
// 4-byte frame (CHAN_ID, data[23:16], data[15:8], data[7:0]) on a valid/ready byte stream.
module status_frame_tx #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [7:0]  CHAN_ID = 8'h53
) (
  input  logic             clk,
  input  logic             rst_n,
  status_frame_tx_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_B2, S_B1, S_B0} state_e;

  state_e          state_q, state_d;
  logic [23:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   ovw_idx;
  logic [LW-1:0]   level_q, level_d;
  logic [23:0]     frame_q, frame_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_valid_q, tx_valid_d;
  logic            overflow_q, overflow_d;
  logic            accept, full, not_empty, pop, do_push, do_ovw;

  assign accept    = tx_valid_q && bus.tx_ready;
  assign full      = (level_q == LW'(DEPTH));
  assign not_empty = (level_q != '0);

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: if (not_empty) begin
        pop     = 1'b1;
        state_d = S_HDR;
      end
      S_HDR:  if (accept) state_d = S_B2;
      S_B2:   if (accept) state_d = S_B1;
      S_B1:   if (accept) state_d = S_B0;
      S_B0:   if (accept) begin
        if (not_empty) begin
          pop     = 1'b1;
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so tx_byte/tx_valid come straight off flops.
  always_comb begin
    frame_d    = pop ? mem_q[rd_ptr_q] : frame_q;
    tx_valid_d = (state_d != S_IDLE);
    tx_byte_d  = 8'h00;
    unique case (state_d)
      S_HDR:   tx_byte_d = CHAN_ID;
      S_B2:    tx_byte_d = frame_d[23:16];
      S_B1:    tx_byte_d = frame_d[15:8];
      S_B0:    tx_byte_d = frame_d[7:0];
      default: tx_byte_d = 8'h00;
    endcase
  end

  // A pop on the same edge frees a slot, so a write into a full FIFO is then a normal push.
  always_comb begin
    do_push  = bus.in_wr && (!full || pop);
    do_ovw   = bus.in_wr && full && !pop;
    ovw_idx  = wr_ptr_q - PW'(1);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(pop);
    if (do_ovw)             overflow_d = 1'b1;
    else if (bus.clear_ovf) overflow_d = 1'b0;
    else                    overflow_d = overflow_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      frame_q    <= '0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      frame_q    <= frame_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage array has no reset; level and pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push)     mem_q[wr_ptr_q] <= bus.in_data;
    else if (do_ovw) mem_q[ovw_idx]  <= bus.in_data;
  end

  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_status_frame_tx.sv
// Bench for status_frame_tx: directed scenarios plus a randomized run against a
// queue-based model of the FIFO and the outgoing byte stream.
module tb_status_frame_tx;
  localparam int unsigned DEPTH   = 4;
  localparam logic [7:0]  CHAN_ID = 8'h53;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: words waiting in the FIFO, and bytes still to be sent from the current frame.
  logic [23:0] m_q[$];
  logic [7:0]  m_cur[$];
  bit          m_ovf;

  status_frame_tx_if #(.DEPTH(DEPTH)) bus ();

  status_frame_tx #(.DEPTH(DEPTH), .CHAN_ID(CHAN_ID)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.in_data   = 24'h0;
    bus.in_wr     = 1'b0;
    bus.clear_ovf = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    bus.tx_ready = 1'b0;
    m_q.delete();
    m_cur.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock edge: advance the model from the inputs applied, then settle 1 time unit.
  task automatic tick();
    bit          popped, set_ovf;
    int          lvl;
    logic [23:0] w;
    @(posedge clk);
    popped  = 1'b0;
    set_ovf = 1'b0;
    lvl     = m_q.size();
    if (m_cur.size() != 0 && bus.tx_ready) void'(m_cur.pop_front());
    if (m_cur.size() == 0 && lvl > 0) begin
      w      = m_q.pop_front();
      m_cur  = {CHAN_ID, w[23:16], w[15:8], w[7:0]};
      popped = 1'b1;
    end
    if (bus.in_wr) begin
      if (lvl < int'(DEPTH) || popped) m_q.push_back(bus.in_data);
      else begin
        m_q[m_q.size()-1] = bus.in_data;
        m_ovf   = 1'b1;
        set_ovf = 1'b1;
      end
    end
    if (bus.clear_ovf && !set_ovf) m_ovf = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.tx_valid); end
    n_checks++; if (bus.tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte got=%h exp=00", bus.tx_byte); end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_b [4];
    exp_b = '{8'h53, 8'h12, 8'h34, 8'h56};
    apply_reset();
    bus.tx_ready = 1'b1;
    bus.in_data  = 24'h123456;
    bus.in_wr    = 1'b1;
    tick();
    drive_idle();
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_early got=%b exp=0", bus.tx_valid); end
    n_checks++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL t1_level_write got=%0d exp=1", bus.level); end
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp_b[i]) begin
        n_fail++; $display("FAIL t1_byte%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_byte, exp_b[i]);
      end
      tick();
    end
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_end got=%b exp=0", bus.tx_valid); end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL t1_level_end got=%0d exp=0", bus.level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [8];
    exp_b = '{8'h53, 8'hA1, 8'hB2, 8'hC3, 8'h53, 8'h0F, 8'h0F, 8'h0F};
    apply_reset();
    bus.tx_ready = 1'b0;
    bus.in_data  = 24'hA1B2C3;
    bus.in_wr    = 1'b1;
    tick();
    bus.in_data  = 24'h0F0F0F;
    tick();
    drive_idle();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h53) begin
        n_fail++; $display("FAIL t2_stall%0d got=%b/%h exp=1/53", i, bus.tx_valid, bus.tx_byte);
      end
      tick();
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp_b[i]) begin
        n_fail++; $display("FAIL t2_byte%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_byte, exp_b[i]);
      end
      tick();
    end
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL t2_valid_end got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_overflow();
    logic [23:0] w [6];
    logic [23:0] order [5];
    logic [7:0]  exp_b;
    for (int i = 0; i < 6; i++) w[i] = 24'($urandom);
    order = '{w[0], w[1], w[2], w[3], w[5]};
    apply_reset();
    bus.tx_ready = 1'b0;
    bus.in_wr    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = w[i];
      tick();
    end
    drive_idle();
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL t3_level got=%0d exp=4", bus.level); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL t3_ovf got=%b exp=1", bus.overflow); end
    bus.tx_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 4; b++) begin
        exp_b = (b == 0) ? CHAN_ID : order[f][23 - 8*(b-1) -: 8];
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp_b) begin
          n_fail++; $display("FAIL t3_f%0d_b%0d got=%b/%h exp=1/%h", f, b, bus.tx_valid, bus.tx_byte, exp_b);
        end
        tick();
      end
    end
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL t3_valid_end got=%b exp=0", bus.tx_valid); end
  endtask

  task automatic test_clear_ovf();
    apply_reset();
    bus.tx_ready = 1'b0;
    bus.in_wr    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 24'h100000 + 24'(i);
      tick();
    end
    bus.in_data   = 24'h100006;
    bus.clear_ovf = 1'b1;
    tick();
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL t4_set_wins got=%b exp=1", bus.overflow); end
    bus.in_wr = 1'b0;
    tick();
    bus.clear_ovf = 1'b0;
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL t4_clear got=%b exp=0", bus.overflow); end
  endtask

  // Continues from test_clear_ovf: FIFO full, frame 0x100000 parked on its header.
  task automatic test_full_push_pop();
    logic [23:0] order [5];
    logic [7:0]  exp_b;
    order = '{24'h100001, 24'h100002, 24'h100003, 24'h100006, 24'h100007};
    bus.tx_ready = 1'b1;
    repeat (3) tick();
    bus.in_data = 24'h100007;
    bus.in_wr   = 1'b1;
    tick();
    drive_idle();
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL t5_level got=%0d exp=4", bus.level); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL t5_ovf got=%b exp=0", bus.overflow); end
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 4; b++) begin
        exp_b = (b == 0) ? CHAN_ID : order[f][23 - 8*(b-1) -: 8];
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp_b) begin
          n_fail++; $display("FAIL t5_f%0d_b%0d got=%b/%h exp=1/%h", f, b, bus.tx_valid, bus.tx_byte, exp_b);
        end
        tick();
      end
    end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL t5_level_end got=%0d exp=0", bus.level); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    bus.tx_ready = 1'b1;
    bus.in_wr    = 1'b1;
    bus.in_data  = 24'hDEAD42;
    tick();
    bus.in_data  = 24'h111111;
    tick();
    bus.in_data  = 24'h222222;
    tick();
    drive_idle();
    tick();
    bus.tx_ready = 1'b0;
    n_checks++; if (bus.tx_byte !== 8'hAD) begin n_fail++; $display("FAIL t6_in_b1 got=%h exp=ad", bus.tx_byte); end
    n_checks++; if (bus.level !== 3'd2) begin n_fail++; $display("FAIL t6_queued got=%0d exp=2", bus.level); end
    #2;
    rst_n = 1'b0;
    m_q.delete();
    m_cur.delete();
    m_ovf = 1'b0;
    #1;
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL t6_async_valid got=%b exp=0", bus.tx_valid); end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL t6_async_level got=%0d exp=0", bus.level); end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL t6_quiet%0d got=%b exp=0", i, bus.tx_valid); end
    end
  endtask

  task automatic test_random();
    bit         exp_valid;
    logic [7:0] exp_byte;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      bus.in_wr     = ($urandom_range(0, 99) < 50);
      bus.in_data   = 24'($urandom);
      bus.tx_ready  = ($urandom_range(0, 99) < 65);
      bus.clear_ovf = ($urandom_range(0, 99) < 8);
      tick();
      exp_valid = (m_cur.size() != 0);
      exp_byte  = exp_valid ? m_cur[0] : 8'h00;
      n_checks++;
      if (bus.tx_valid !== exp_valid || (exp_valid && bus.tx_byte !== exp_byte)) begin
        n_fail++; $display("FAIL rnd_stream cyc=%0d got=%b/%h exp=%b/%h", i, bus.tx_valid, bus.tx_byte, exp_valid, exp_byte);
      end
      n_checks++;
      if (bus.level !== 3'(m_q.size()) || bus.overflow !== m_ovf) begin
        n_fail++; $display("FAIL rnd_status cyc=%0d got=%0d/%b exp=%0d/%b", i, bus.level, bus.overflow, m_q.size(), m_ovf);
      end
    end
    drive_idle();
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.tx_ready = 1'b0;
    drive_idle();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_clear_ovf();
    test_full_push_pop();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
